// File: rtl/zero_cmp_arbiter.sv
// Two-requester round-robin front end for a shared compare-with-zero unit.
// One operation at a time: grant in IDLE, compare in EVAL, hold the result in RESP.

// Shared comparator: reports whether the operand is zero or negative.
module compare_with_zero_32bit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic [WIDTH-1:0] op_i,
  output logic             equal_o,
  output logic             less_o
);

  // Zero test and sign test of the two's complement operand.
  always_comb begin
    equal_o = (op_i == '0);
    less_o  = op_i[WIDTH-1];
  end

endmodule

module zero_cmp_arbiter #(
  parameter int unsigned WIDTH   = 32,
  parameter bit          RR_INIT = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [WIDTH-1:0] req0_data,
  output logic             req0_ready,
  input  logic             req1_valid,
  input  logic [WIDTH-1:0] req1_data,
  output logic             req1_ready,
  output logic             resp0_valid,
  input  logic             resp0_ready,
  output logic             resp1_valid,
  input  logic             resp1_ready,
  output logic             resp_equal,
  output logic             resp_less,
  output logic             busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EVAL = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic             prio_q, prio_d;
  logic             id_q, id_d;
  logic [WIDTH-1:0] operand_q, operand_d;
  logic             equal_q, equal_d;
  logic             less_q, less_d;

  logic             grant0_c, grant1_c;
  logic             cmp_equal, cmp_less;
  logic             resp_take_c;

  compare_with_zero_32bit #(
    .WIDTH (WIDTH)
  ) u_cmp (
    .op_i    (operand_q),
    .equal_o (cmp_equal),
    .less_o  (cmp_less)
  );

  // Grant: lone requester wins; on contention the priority holder wins.
  always_comb begin
    grant0_c = 1'b0;
    grant1_c = 1'b0;
    if (state_q == IDLE && !reset) begin
      if (req0_valid && req1_valid) begin
        grant0_c = ~prio_q;
        grant1_c = prio_q;
      end else begin
        grant0_c = req0_valid;
        grant1_c = req1_valid;
      end
    end
  end

  // Response handshake from the requester that owns the current operation.
  always_comb begin
    resp_take_c = id_q ? resp1_ready : resp0_ready;
  end

  // Next-state and datapath update.
  always_comb begin
    state_d   = state_q;
    prio_d    = prio_q;
    id_d      = id_q;
    operand_d = operand_q;
    equal_d   = equal_q;
    less_d    = less_q;
    case (state_q)
      IDLE: begin
        if (grant0_c) begin
          operand_d = req0_data;
          id_d      = 1'b0;
          state_d   = EVAL;
        end else if (grant1_c) begin
          operand_d = req1_data;
          id_d      = 1'b1;
          state_d   = EVAL;
        end
      end
      EVAL: begin
        equal_d = cmp_equal;
        less_d  = cmp_less;
        state_d = RESP;
      end
      RESP: begin
        if (resp_take_c) begin
          prio_d  = ~id_q;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      prio_q    <= RR_INIT;
      id_q      <= 1'b0;
      operand_q <= '0;
      equal_q   <= 1'b0;
      less_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      prio_q    <= prio_d;
      id_q      <= id_d;
      operand_q <= operand_d;
      equal_q   <= equal_d;
      less_q    <= less_d;
    end
  end

  // Output decode from registered state.
  always_comb begin
    req0_ready  = grant0_c;
    req1_ready  = grant1_c;
    resp0_valid = (state_q == RESP) && !id_q;
    resp1_valid = (state_q == RESP) && id_q;
    resp_equal  = equal_q;
    resp_less   = less_q;
    busy        = (state_q != IDLE);
  end

endmodule

// File: tb/tb_zero_cmp_arbiter.sv
// Directed bench for zero_cmp_arbiter: hand-computed expectations per step.
module tb_zero_cmp_arbiter;

  localparam int unsigned WIDTH = 32;

  logic             clk;
  logic             reset;
  logic             req0_valid, req1_valid;
  logic [WIDTH-1:0] req0_data, req1_data;
  logic             req0_ready, req1_ready;
  logic             resp0_valid, resp1_valid;
  logic             resp0_ready, resp1_ready;
  logic             resp_equal, resp_less, busy;

  int checks;
  int errors;

  zero_cmp_arbiter #(
    .WIDTH   (WIDTH),
    .RR_INIT (1'b0)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .req0_valid  (req0_valid),
    .req0_data   (req0_data),
    .req0_ready  (req0_ready),
    .req1_valid  (req1_valid),
    .req1_data   (req1_data),
    .req1_ready  (req1_ready),
    .resp0_valid (resp0_valid),
    .resp0_ready (resp0_ready),
    .resp1_valid (resp1_valid),
    .resp1_ready (resp1_ready),
    .resp_equal  (resp_equal),
    .resp_less   (resp_less),
    .busy        (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Let combinational outputs follow freshly driven inputs.
  task automatic settle();
    #1;
  endtask

  // Pack all DUT outputs: {req0_rdy, req1_rdy, resp0_v, resp1_v, eq, lt, busy}.
  function automatic logic [6:0] outs();
    return {req0_ready, req1_ready, resp0_valid, resp1_valid, resp_equal, resp_less, busy};
  endfunction

  task automatic do_reset();
    reset = 1'b1;
    settle();
    chk("reset_outs", 32'(outs()), 32'h0);
    step();
    step();
    reset = 1'b0;
    settle();
  endtask

  initial begin
    checks      = 0;
    errors      = 0;
    reset       = 1'b1;
    req0_valid  = 1'b0;
    req1_valid  = 1'b0;
    req0_data   = '0;
    req1_data   = '0;
    resp0_ready = 1'b0;
    resp1_ready = 1'b0;
    step();
    do_reset();
    chk("idle_outs", 32'(outs()), 32'h0);

    // T1: req0 only, operand zero
    req0_valid = 1'b1;
    req0_data  = 32'h0000_0000;
    settle();
    chk("t1_req0_ready", 32'(req0_ready), 32'h1);
    chk("t1_req1_ready", 32'(req1_ready), 32'h0);
    chk("t1_busy_idle", 32'(busy), 32'h0);
    step();
    req0_valid = 1'b0;
    settle();
    chk("t1_eval_outs", 32'(outs()), 32'b000_0001);
    step();
    chk("t1_resp_outs", 32'(outs()), 32'b001_0101);
    resp0_ready = 1'b1;
    step();
    resp0_ready = 1'b0;
    chk("t1_back_idle", 32'(busy), 32'h0);
    chk("t1_resp0_gone", 32'(resp0_valid), 32'h0);

    // T2: req1 only, negative operand
    req1_valid = 1'b1;
    req1_data  = 32'h8000_0001;
    settle();
    chk("t2_req1_ready", 32'(req1_ready), 32'h1);
    chk("t2_req0_ready", 32'(req0_ready), 32'h0);
    step();
    req1_valid = 1'b0;
    step();
    chk("t2_resp_outs", 32'(outs()), 32'b000_1011);
    resp1_ready = 1'b1;
    resp0_ready = 1'b1;
    step();
    resp1_ready = 1'b0;
    resp0_ready = 1'b0;
    chk("t2_back_idle", 32'(busy), 32'h0);

    // T3: contention after reset, round robin 0,1,0 with both held valid
    do_reset();
    req0_valid = 1'b1;
    req0_data  = 32'h0000_0001;
    req1_valid = 1'b1;
    req1_data  = 32'h0000_0000;
    settle();
    chk("t3a_grant", 32'({req0_ready, req1_ready}), 32'b10);
    step();
    chk("t3a_eval_no_grant", 32'({req0_ready, req1_ready}), 32'b00);
    step();
    chk("t3a_resp", 32'({resp0_valid, resp1_valid, resp_equal, resp_less}), 32'b1000);
    chk("t3a_resp_no_grant", 32'({req0_ready, req1_ready}), 32'b00);
    resp0_ready = 1'b1;
    step();
    resp0_ready = 1'b0;
    settle();
    chk("t3b_grant", 32'({req0_ready, req1_ready}), 32'b01);
    step();
    step();
    chk("t3b_resp", 32'({resp0_valid, resp1_valid, resp_equal, resp_less}), 32'b0110);
    resp1_ready = 1'b1;
    step();
    resp1_ready = 1'b0;
    settle();
    chk("t3c_grant", 32'({req0_ready, req1_ready}), 32'b10);
    step();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    step();
    chk("t3c_resp", 32'({resp0_valid, resp1_valid, resp_equal, resp_less}), 32'b1000);
    resp0_ready = 1'b1;
    step();
    resp0_ready = 1'b0;

    // T4: response stall of 5 cycles; req1 waits
    req0_valid = 1'b1;
    req0_data  = 32'h8000_0000;
    settle();
    chk("t4_grant", 32'(req0_ready), 32'h1);
    step();
    req0_valid = 1'b0;
    step();
    req1_valid = 1'b1;
    req1_data  = 32'h7FFF_FFFF;
    for (int i = 0; i < 5; i++) begin
      settle();
      chk($sformatf("t4_hold_%0d", i), 32'(outs()), 32'b001_0011);
      step();
    end
    resp1_ready = 1'b1;
    settle();
    chk("t4_foreign_ready_ignored", 32'(outs()), 32'b001_0011);
    step();
    resp1_ready = 1'b0;
    chk("t4_still_held", 32'(resp0_valid), 32'h1);
    resp0_ready = 1'b1;
    step();
    resp0_ready = 1'b0;
    settle();
    chk("t4_req1_granted", 32'({req0_ready, req1_ready}), 32'b01);
    step();
    req1_valid = 1'b0;
    step();
    chk("t4_req1_resp", 32'({resp0_valid, resp1_valid, resp_equal, resp_less}), 32'b0100);
    resp1_ready = 1'b1;
    step();
    resp1_ready = 1'b0;

    // T5: reset during EVAL discards the result
    req0_valid = 1'b1;
    req0_data  = 32'hFFFF_FFFF;
    settle();
    chk("t5_grant", 32'(req0_ready), 32'h1);
    step();
    req0_valid  = 1'b0;
    resp0_ready = 1'b0;
    settle();
    chk("t5_in_eval", 32'(busy), 32'h1);
    do_reset();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("t5_quiet_%0d", i), 32'(outs()), 32'h0);
      step();
    end
    req0_valid = 1'b1;
    req0_data  = 32'h0000_0005;
    settle();
    chk("t5_regrant", 32'(req0_ready), 32'h1);
    step();
    req0_valid = 1'b0;
    step();
    chk("t5_resp", 32'(outs()), 32'b001_0001);
    resp0_ready = 1'b1;
    step();
    resp0_ready = 1'b0;

    // T6: back-to-back req0 stream, one accept every 3 cycles
    begin
      logic [31:0] data_v [4];
      logic [1:0]  exp_v  [4];
      data_v[0] = 32'h0000_0001; exp_v[0] = 2'b00;
      data_v[1] = 32'h0000_0000; exp_v[1] = 2'b10;
      data_v[2] = 32'h8000_0000; exp_v[2] = 2'b01;
      data_v[3] = 32'h7FFF_FFFF; exp_v[3] = 2'b00;
      resp0_ready = 1'b1;
      req0_valid  = 1'b1;
      for (int k = 0; k < 4; k++) begin
        req0_data = data_v[k];
        settle();
        chk($sformatf("t6_accept_%0d", k), 32'(req0_ready), 32'h1);
        step();
        chk($sformatf("t6_eval_ready_%0d", k), 32'(req0_ready), 32'h0);
        step();
        chk($sformatf("t6_resp_%0d", k), 32'({resp0_valid, resp_equal, resp_less}),
            32'({1'b1, exp_v[k]}));
        step();
      end
      req0_valid  = 1'b0;
      resp0_ready = 1'b0;
      settle();
      chk("t6_final_idle", 32'(busy), 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
